// File: rtl/rc4_pkg.sv
// RC4 phase sequencer shared types: FSM state enum, phase codes, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_pkg;

    localparam int ADDR_W = 8;   // S-memory address width (256 entries)
    localparam int DATA_W = 8;   // S-memory data width
    localparam int KEY_W  = 24;  // secret key width

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_SHUF_GO,
        ST_SHUF_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_NEXT_KEY,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_IDLE = 2'd0;
    localparam phase_t PH_INIT = 2'd1;
    localparam phase_t PH_SHUF = 2'd2;
    localparam phase_t PH_DEC  = 2'd3;

endpackage

// File: rtl/rc4_phase_sequencer_if.sv
// Control and S-memory port bundle between the sequencer and its environment.
// Latency: n/a (wires only).
// Backpressure: none; start/fin are single-cycle pulses, no ready path.
// Modports: master = sequencer (drives control outputs and the muxed S port),
//           slave  = environment (top-level controls and the three phase FSMs).
interface rc4_phase_sequencer_if
    import rc4_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DATA_W = DATA_W,
    parameter int P_KEY_W  = KEY_W
);
    logic                start;
    logic [P_KEY_W-1:0]  key_in;
    logic                busy;
    logic                done;
    logic                fail;
    phase_t              phase;
    logic [P_KEY_W-1:0]  key;
    logic                init_start, shuf_start, dec_start;
    logic                init_fin, shuf_fin, dec_fin;
    logic                dec_ok;
    logic [P_ADDR_W-1:0] init_addr, shuf_addr, dec_addr;
    logic [P_DATA_W-1:0] init_wdata, shuf_wdata, dec_wdata;
    logic                init_wren, shuf_wren, dec_wren;
    logic [P_ADDR_W-1:0] s_addr;
    logic [P_DATA_W-1:0] s_wdata;
    logic                s_wren;

    modport master (
        input  start, key_in, init_fin, shuf_fin, dec_fin, dec_ok,
        input  init_addr, shuf_addr, dec_addr,
        input  init_wdata, shuf_wdata, dec_wdata,
        input  init_wren, shuf_wren, dec_wren,
        output busy, done, fail, phase, key,
        output init_start, shuf_start, dec_start,
        output s_addr, s_wdata, s_wren
    );

    modport slave (
        output start, key_in, init_fin, shuf_fin, dec_fin, dec_ok,
        output init_addr, shuf_addr, dec_addr,
        output init_wdata, shuf_wdata, dec_wdata,
        output init_wren, shuf_wren, dec_wren,
        input  busy, done, fail, phase, key,
        input  init_start, shuf_start, dec_start,
        input  s_addr, s_wdata, s_wren
    );

endinterface

// File: rtl/s_mem_port_mux.sv
// Selects the active phase's S-memory port; idle phase drives zeros.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_phase select, i_{init,shuf,dec}_{addr,wdata,wren} sources, o_s_{addr,wdata,wren}.
module s_mem_port_mux
    import rc4_pkg::*;
(
    input  phase_t            i_phase,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic [DATA_W-1:0] i_init_wdata,
    input  logic              i_init_wren,
    input  logic [ADDR_W-1:0] i_shuf_addr,
    input  logic [DATA_W-1:0] i_shuf_wdata,
    input  logic              i_shuf_wren,
    input  logic [ADDR_W-1:0] i_dec_addr,
    input  logic [DATA_W-1:0] i_dec_wdata,
    input  logic              i_dec_wren,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_wdata,
    output logic              o_s_wren
);

    always_comb begin
        o_s_addr  = '0;
        o_s_wdata = '0;
        o_s_wren  = 1'b0;
        case (i_phase)
            PH_INIT: begin
                o_s_addr  = i_init_addr;
                o_s_wdata = i_init_wdata;
                o_s_wren  = i_init_wren;
            end
            PH_SHUF: begin
                o_s_addr  = i_shuf_addr;
                o_s_wdata = i_shuf_wdata;
                o_s_wren  = i_shuf_wren;
            end
            PH_DEC: begin
                o_s_addr  = i_dec_addr;
                o_s_wdata = i_dec_wdata;
                o_s_wren  = i_dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs S-init, key shuffle and decrypt phase FSMs in order and owns the S-memory port.
// Latency: accepted start or fin at edge t -> next phase start pulse in cycle t+1.
// Backpressure: none; start is ignored while busy, stray fins are ignored.
// Ports: clk, reset (async, active high), bus (rc4_phase_sequencer_if.master).
// Build option: RC4_KEY_SEARCH_EN retries successive keys up to KEY_MAX until dec_ok.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
)(
    input  logic                  clk,
    input  logic                  reset,
    rc4_phase_sequencer_if.master bus
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [KEY_W-1:0] r_key;
    logic             w_accept;
    phase_t           w_phase;
    logic             w_busy;

    // Start is only honoured from the three resting states.
    assign w_accept = bus.start &&
                      (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FAIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_key <= bus.key_in;
            end
`ifdef RC4_KEY_SEARCH_EN
            else if (r_state == ST_NEXT_KEY) begin
                r_key <= r_key + KEY_W'(1);
            end
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: if (bus.start) w_next = ST_INIT_GO;
            ST_INIT_GO:   w_next = ST_INIT_WAIT;
            ST_INIT_WAIT: if (bus.init_fin) w_next = ST_SHUF_GO;
            ST_SHUF_GO:   w_next = ST_SHUF_WAIT;
            ST_SHUF_WAIT: if (bus.shuf_fin) w_next = ST_DEC_GO;
            ST_DEC_GO:    w_next = ST_DEC_WAIT;
            ST_DEC_WAIT: begin
                if (bus.dec_fin) begin
`ifdef RC4_KEY_SEARCH_EN
                    // KEY_MAX is checked before incrementing so the key never wraps.
                    if (bus.dec_ok)            w_next = ST_DONE;
                    else if (r_key == KEY_MAX) w_next = ST_FAIL;
                    else                       w_next = ST_NEXT_KEY;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_NEXT_KEY:  w_next = ST_INIT_GO;
            default:      w_next = ST_IDLE;
        endcase
    end

    // GO and WAIT of a phase share the phase code, so the memory port is
    // handed over in the GO cycle already.
    always_comb begin
        w_phase = PH_IDLE;
        case (r_state)
            ST_INIT_GO, ST_INIT_WAIT: w_phase = PH_INIT;
            ST_SHUF_GO, ST_SHUF_WAIT: w_phase = PH_SHUF;
            ST_DEC_GO,  ST_DEC_WAIT:  w_phase = PH_DEC;
            default:                  w_phase = PH_IDLE;
        endcase
    end

    assign w_busy = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FAIL);

    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == ST_DONE);
`ifdef RC4_KEY_SEARCH_EN
    assign bus.fail       = (r_state == ST_FAIL);
`else
    assign bus.fail       = 1'b0;
    // dec_ok and KEY_MAX only matter when key search is built in.
    logic w_unused;
    assign w_unused = bus.dec_ok ^ (^KEY_MAX);
`endif
    assign bus.phase      = w_phase;
    assign bus.key        = r_key;
    assign bus.init_start = (r_state == ST_INIT_GO);
    assign bus.shuf_start = (r_state == ST_SHUF_GO);
    assign bus.dec_start  = (r_state == ST_DEC_GO);

    s_mem_port_mux u_s_mem_port_mux (
        .i_phase      (w_phase),
        .i_init_addr  (bus.init_addr),
        .i_init_wdata (bus.init_wdata),
        .i_init_wren  (bus.init_wren),
        .i_shuf_addr  (bus.shuf_addr),
        .i_shuf_wdata (bus.shuf_wdata),
        .i_shuf_wren  (bus.shuf_wren),
        .i_dec_addr   (bus.dec_addr),
        .i_dec_wdata  (bus.dec_wdata),
        .i_dec_wren   (bus.dec_wren),
        .o_s_addr     (bus.s_addr),
        .o_s_wdata    (bus.s_wdata),
        .o_s_wren     (bus.s_wren)
    );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: phase-level model plus emulated phase FSMs.
// Latency: n/a.
// Backpressure: n/a.
module tb_rc4_phase_sequencer;
    import rc4_pkg::*;

`ifdef RC4_KEY_SEARCH_EN
    localparam logic [23:0] TB_KEY_MAX = 24'd5;
`else
    localparam logic [23:0] TB_KEY_MAX = 24'h3FFFFF;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rc4_phase_sequencer_if intf();

    rc4_phase_sequencer #(.KEY_MAX(TB_KEY_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Phase-level model: which phase is running, whether its start pulse is
    // due this cycle, and the run outcome.
    logic        m_busy, m_done, m_fail, m_go;
    logic [1:0]  m_phase;
    logic [23:0] m_key;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_fail <= 0; m_go <= 0; m_phase <= 0; m_key <= 0;
        end else if (!m_busy) begin
            if (intf.start) begin
                m_busy <= 1; m_phase <= 1; m_go <= 1; m_key <= intf.key_in;
                m_done <= 0; m_fail <= 0;
            end
        end else if (m_phase == 0) begin
            m_phase <= 1; m_go <= 1; m_key <= m_key + 24'd1;
        end else if (m_go) begin
            m_go <= 0;
        end else if (m_phase == 1 && intf.init_fin) begin
            m_phase <= 2; m_go <= 1;
        end else if (m_phase == 2 && intf.shuf_fin) begin
            m_phase <= 3; m_go <= 1;
        end else if (m_phase == 3 && intf.dec_fin) begin
            m_phase <= 0;
`ifdef RC4_KEY_SEARCH_EN
            if (intf.dec_ok) begin
                m_busy <= 0; m_done <= 1;
            end else if (m_key == TB_KEY_MAX) begin
                m_busy <= 0; m_fail <= 1;
            end
`else
            m_busy <= 0; m_done <= 1;
`endif
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [31:0] exp_ctrl, act_ctrl;
        logic [16:0] exp_mem, act_mem;
        if (chk_en && !reset) begin
            exp_ctrl = {m_busy, m_done, m_fail, m_phase, m_key,
                        m_go && m_phase == 1, m_go && m_phase == 2, m_go && m_phase == 3};
            act_ctrl = {intf.busy, intf.done, intf.fail, intf.phase, intf.key,
                        intf.init_start, intf.shuf_start, intf.dec_start};
            chk("ctrl", 64'(act_ctrl), 64'(exp_ctrl));
            case (m_phase)
                2'd1:    exp_mem = {intf.init_addr, intf.init_wdata, intf.init_wren};
                2'd2:    exp_mem = {intf.shuf_addr, intf.shuf_wdata, intf.shuf_wren};
                2'd3:    exp_mem = {intf.dec_addr,  intf.dec_wdata,  intf.dec_wren};
                default: exp_mem = '0;
            endcase
            act_mem = {intf.s_addr, intf.s_wdata, intf.s_wren};
            chk("mem", 64'(act_mem), 64'(exp_mem));
        end
    end

    // Start-pulse bookkeeping for ordering/latency checks.
    int t_init, t_shuf, t_dec, n_init;
    always @(negedge clk) begin
        if (intf.init_start) begin t_init = cyc; n_init++; end
        if (intf.shuf_start) t_shuf = cyc;
        if (intf.dec_start)  t_dec  = cyc;
    end

    // Emulated phase FSMs and stimulus.
    int          pend = 0;
    int          pend_ph = 0;
    int          fixed_dly = 4;
    bit          rnd = 0;
    bit          stray_en = 0;
    logic [23:0] good_key = 24'h0;

    function automatic int pick_dly();
        return (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 6));
    endfunction

    task automatic step();
        int p;
        @(posedge clk); #1;
        intf.init_fin = 0; intf.shuf_fin = 0; intf.dec_fin = 0;
        if (rnd) begin
            intf.init_addr = 8'($urandom); intf.init_wdata = 8'($urandom); intf.init_wren = 1'($urandom);
            intf.shuf_addr = 8'($urandom); intf.shuf_wdata = 8'($urandom); intf.shuf_wren = 1'($urandom);
            intf.dec_addr  = 8'($urandom); intf.dec_wdata  = 8'($urandom); intf.dec_wren  = 1'($urandom);
            intf.start = m_busy && ($urandom_range(0, 5) == 0);
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                case (pend_ph)
                    1: intf.init_fin = 1;
                    2: intf.shuf_fin = 1;
                    default: intf.dec_fin = 1;
                endcase
            end
        end
        if (intf.init_start) begin pend = pick_dly(); pend_ph = 1; end
        if (intf.shuf_start) begin pend = pick_dly(); pend_ph = 2; end
        if (intf.dec_start)  begin pend = pick_dly(); pend_ph = 3; end
`ifdef RC4_KEY_SEARCH_EN
        intf.dec_ok = (m_key == good_key);
`else
        intf.dec_ok = rnd ? 1'($urandom) : 1'b1;
`endif
        if (stray_en && $urandom_range(0, 3) == 0) begin
            p = $urandom_range(1, 3);
            if (p != int'(m_phase)) begin
                case (p)
                    1: intf.init_fin = 1;
                    2: intf.shuf_fin = 1;
                    default: intf.dec_fin = 1;
                endcase
            end
        end
    endtask

    task automatic start_run(input logic [23:0] k);
        intf.key_in = k;
        intf.start = 1;
        step();
        if (!rnd) intf.start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (intf.busy && n < 400) begin step(); n++; end
        if (intf.busy) begin
            failures++;
            $display("FAIL %s timeout busy=%0b required=0", name, intf.busy);
        end
    endtask

    task automatic wait_phase_wait(input logic [1:0] ph, input string name);
        int n = 0;
        while (!(intf.phase == ph && !intf.init_start && !intf.shuf_start && !intf.dec_start) && n < 100) begin
            step(); n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s timeout phase=%0d required=%0d", name, intf.phase, ph);
        end
    endtask

    initial begin
        intf.start = 0; intf.key_in = 0;
        intf.init_fin = 0; intf.shuf_fin = 0; intf.dec_fin = 0; intf.dec_ok = 0;
        intf.init_addr = 0; intf.init_wdata = 0; intf.init_wren = 1;
        intf.shuf_addr = 0; intf.shuf_wdata = 0; intf.shuf_wren = 0;
        intf.dec_addr = 0;  intf.dec_wdata = 0;  intf.dec_wren = 0;
        t_init = 0; t_shuf = 0; t_dec = 0; n_init = 0;

        // Reset state, with a live init write request that must not leak out.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 64'(intf.busy), 64'd0);
        chk("rst_done_fail", 64'({intf.done, intf.fail}), 64'd0);
        chk("rst_phase", 64'(intf.phase), 64'd0);
        chk("rst_key", 64'(intf.key), 64'd0);
        chk("rst_starts", 64'({intf.init_start, intf.shuf_start, intf.dec_start}), 64'd0);
        chk("rst_mem", 64'({intf.s_addr, intf.s_wdata, intf.s_wren}), 64'd0);
        intf.init_wren = 0;
        reset = 0;
        chk_en = 1;

        // Directed run, fins four cycles after each start pulse.
        fixed_dly = 4; good_key = 24'h000249;
        start_run(24'h000249);
        wait_idle("run249");
        chk("run249_done", 64'(intf.done), 64'd1);
        chk("run249_busy", 64'(intf.busy), 64'd0);
        chk("run249_key", 64'(intf.key), 64'h249);
        chk("run249_init_to_shuf", 64'(t_shuf - t_init), 64'd5);
        chk("run249_shuf_to_dec", 64'(t_dec - t_shuf), 64'd5);

        // Mux ownership and stray fin in INIT_WAIT.
        fixed_dly = 8; good_key = 24'h000011;
        start_run(24'h000011);
        step();
        intf.init_addr = 8'h05; intf.init_wren = 1;
        intf.shuf_addr = 8'hAA; intf.shuf_wren = 1; intf.shuf_fin = 1;
        #1;
        chk("mux_addr", 64'(intf.s_addr), 64'h05);
        chk("mux_wren", 64'(intf.s_wren), 64'd1);
        step();
        chk("stray_phase", 64'(intf.phase), 64'd1);
        chk("stray_no_shuf_start", 64'(intf.shuf_start), 64'd0);
        wait_idle("run11");

        // Start held through SHUF_WAIT, then restart after done.
        fixed_dly = 4; good_key = 24'h000022; n_init = 0;
        start_run(24'h000022);
        wait_phase_wait(2'd2, "shuf_wait");
        intf.start = 1;
        wait_phase_wait(2'd3, "dec_wait");
        intf.start = 0;
        wait_idle("run22");
        chk("held_start_init_count", 64'(n_init), 64'd1);
        chk("run22_done", 64'(intf.done), 64'd1);
        good_key = 24'h000033;
        start_run(24'h000033);
        chk("restart_done_clear", 64'(intf.done), 64'd0);
        chk("restart_busy", 64'(intf.busy), 64'd1);
        wait_idle("run33");

        // Reset mid-DEC_WAIT with an active decrypt write.
        start_run(24'h000044);
        wait_phase_wait(2'd3, "dec_wait_rst");
        intf.dec_addr = 8'h07; intf.dec_wren = 1;
        #1;
        chk("pre_rst_wren", 64'(intf.s_wren), 64'd1);
        #1 reset = 1;
        #1;
        chk("async_rst_wren", 64'(intf.s_wren), 64'd0);
        chk("async_rst_ctrl", 64'({intf.busy, intf.done, intf.fail, intf.phase, intf.key}), 64'd0);
        pend = 0;
        step();
        reset = 0;
        intf.dec_wren = 0;

`ifdef RC4_KEY_SEARCH_EN
        // Key search: good key 3 from key 0; then exhaustion from key 3 to KEY_MAX=5.
        good_key = 24'd3; n_init = 0;
        start_run(24'd0);
        wait_idle("search_ok");
        chk("search_init_count", 64'(n_init), 64'd4);
        chk("search_done", 64'({intf.done, intf.fail}), 64'b10);
        chk("search_key", 64'(intf.key), 64'd3);
        good_key = 24'hFFFFFF; n_init = 0;
        start_run(24'd3);
        wait_idle("search_fail");
        chk("exhaust_init_count", 64'(n_init), 64'd3);
        chk("exhaust_fail", 64'({intf.done, intf.fail}), 64'b01);
        chk("exhaust_key", 64'(intf.key), 64'd5);
`endif

        // Randomized runs: random data, delays, strays and spurious starts.
        fixed_dly = 0; rnd = 1; stray_en = 1;
        for (int r = 0; r < 25; r++) begin
`ifdef RC4_KEY_SEARCH_EN
            good_key = 24'($urandom_range(0, 7));
            start_run(24'($urandom_range(0, 5)));
`else
            start_run(24'($urandom));
`endif
            wait_idle("rand_run");
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
        end
        rnd = 0; stray_en = 0;
        intf.start = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
